// File: rtl/aes_pkg.sv
// Shared AES constants, byte-substitution tables and FSM state type for the
// encryption and decryption round datapaths.
package aes_pkg;

    localparam int BLOCK_W   = 128;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 16;

    // Forward S-box, indexed by input byte value.
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse S-box used by the decryption-side substitution stage.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/SubByte.sv
// Combinational single-byte forward S-box lookup.
module SubByte
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes BYTES_PER_CYCLE bytes per clock through
// shared S-box lanes, completing a 128-bit state in 16/BYTES_PER_CYCLE edges.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BLOCK_W-1:0] state_in,
    input  logic               SubByteEN,
    output logic               SubByteValid,
    output logic [BLOCK_W-1:0] SubByte_Out,
    output logic               busy
);

    localparam int N      = NUM_BYTES / BYTES_PER_CYCLE;
    localparam int GRP_W  = (N > 1) ? $clog2(N) : 1;
    localparam int LANE_W = BYTES_PER_CYCLE * BYTE_W;

    if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
          BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bytes_per_cycle
        $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    fsm_state_t         state_q, state_d;
    logic [GRP_W-1:0]   grp_q, grp_d;
    logic [BLOCK_W-1:0] work_q, work_d;
    logic [BLOCK_W-1:0] out_q, out_d;
    logic               valid_q, valid_d;

    logic               accept;
    logic [GRP_W-1:0]   cur_grp;
    logic [BLOCK_W-1:0] src;
    logic [BLOCK_W-1:0] work_sub;
    logic [LANE_W-1:0]  lane_in, lane_out;

    // The accepting edge substitutes group 0 straight from state_in.
    assign accept  = (state_q == IDLE) && SubByteEN;
    assign cur_grp = accept ? '0 : grp_q;
    assign src     = accept ? state_in : work_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        lane_in = '0;
        for (int g = 0; g < N; g++) begin
            if (cur_grp == GRP_W'(g)) lane_in = src[g*LANE_W +: LANE_W];
        end
    end

    for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_lane
        SubByte u_sbox (
            .in_byte (lane_in[l*BYTE_W +: BYTE_W]),
            .out_byte(lane_out[l*BYTE_W +: BYTE_W])
        );
    end

    always_comb begin
        work_sub = src;
        for (int g = 0; g < N; g++) begin
            if (cur_grp == GRP_W'(g)) work_sub[g*LANE_W +: LANE_W] = lane_out;
        end
    end

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        work_d  = work_q;
        out_d   = out_q;
        valid_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (SubByteEN) begin
                    work_d = work_sub;
                    grp_d  = GRP_W'(1);
                    if (N == 1) begin
                        out_d   = work_sub;
                        valid_d = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                work_d = work_sub;
                grp_d  = grp_q + 1'b1;
                if (grp_q == GRP_W'(N - 1)) begin
                    out_d   = work_sub;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grp_q   <= '0;
            // NOTE: work is a flop bank, not a RAM, so clearing it on reset is cheap and discards a half-done block.
            work_q  <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            work_q  <= work_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign SubByteValid = valid_q;
    assign SubByte_Out  = out_q;
    assign busy         = (state_q == BUSY);

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench: one sub_bytes_iter per legal lane count, all sharing stimulus,
// checked every cycle against an S-box derived from GF(2^8) arithmetic.
module tb_sub_bytes_iter;
    import aes_pkg::*;

    typedef struct {
        logic [127:0] data;
        logic [127:0] src;
        int           edge_n;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, en;
    logic [127:0] state_in, exp_in;
    logic         valid_v [5];
    logic         busy_v  [5];
    logic [127:0] out_v   [5];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 5; k++) begin : g_dut
        sub_bytes_iter #(.BYTES_PER_CYCLE(1 << k)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .state_in    (state_in),
            .SubByteEN   (en),
            .SubByteValid(valid_v[k]),
            .SubByte_Out (out_v[k]),
            .busy        (busy_v[k])
        );
    end

    exp_t         sb [5][$];
    logic [7:0]   sbox_m [256];
    int           cycle   = 0;
    int           n_tests = 0;
    int           n_fail  = 0;
    bit           chk_en  = 1'b0;
    bit           flight   [5];
    int           t0       [5];
    logic [127:0] cur      [5];
    logic [127:0] hold     [5];
    logic         exp_busy [5];

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
        end
        return p;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv;
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            sbox_m[x] = iv ^ {iv[6:0], iv[7]} ^ {iv[5:0], iv[7:6]} ^
                        {iv[4:0], iv[7:5]} ^ {iv[3:0], iv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_state(input logic [127:0] s);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[b*8 +: 8] = sbox_m[s[b*8 +: 8]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // One clock edge: advance the reference model with the inputs sampled at that edge.
    task automatic tick();
        @(posedge clk);
        cycle++;
        for (int k = 0; k < 5; k++) begin
            int nk;
            nk = 16 >> k;
            if (rst) begin
                flight[k] = 1'b0;
                sb[k].delete();
                hold[k] = '0;
            end else if (flight[k]) begin
                if (cycle == t0[k] + nk - 1) begin
                    flight[k] = 1'b0;
                    hold[k]   = cur[k];
                end
            end else if (en) begin
                t0[k]  = cycle;
                cur[k] = exp_in;
                sb[k].push_back('{data: exp_in, src: state_in, edge_n: cycle + nk - 1});
                if (nk == 1) hold[k] = exp_in;
                else         flight[k] = 1'b1;
            end
            exp_busy[k] = flight[k];
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send(input logic [127:0] s, input logic [127:0] x);
        state_in = s;
        exp_in   = x;
        en       = 1'b1;
        tick();
        en       = 1'b0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        exp_t         e;
        logic         exp_v;
        logic [127:0] inv;
        if (chk_en) begin
            for (int k = 0; k < 5; k++) begin
                exp_v = (sb[k].size() > 0) && (sb[k][0].edge_n == cycle);
                check($sformatf("valid bpc%0d cyc%0d", 1 << k, cycle), 128'(valid_v[k]), 128'(exp_v));
                check($sformatf("busy bpc%0d cyc%0d", 1 << k, cycle), 128'(busy_v[k]), 128'(exp_busy[k]));
                if (exp_v) begin
                    e = sb[k].pop_front();
                    check($sformatf("out bpc%0d cyc%0d", 1 << k, cycle), out_v[k], e.data);
                    if (k == 2) begin
                        for (int b = 0; b < 16; b++) inv[b*8 +: 8] = INV_SBOX[out_v[k][b*8 +: 8]];
                        check($sformatf("roundtrip cyc%0d", cycle), inv, e.src);
                    end
                end else begin
                    check($sformatf("hold bpc%0d cyc%0d", 1 << k, cycle), out_v[k], hold[k]);
                end
            end
        end
    end

    initial begin
        logic [7:0]   spot_in  [4];
        logic [7:0]   spot_out [4];
        logic [127:0] s;
        spot_in  = '{8'h00, 8'h01, 8'h53, 8'hff};
        spot_out = '{8'h63, 8'h7c, 8'hed, 8'h16};

        build_sbox();
        rst = 1'b1; en = 1'b0; state_in = '0; exp_in = '0;
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        idle(2);

        // all-zero state
        send(128'h0, {16{8'h63}});
        idle(20);

        // FIPS-197 round-1 vector (byte 0 in the least-significant position)
        send(128'h0848f8e92a8dc69a2be2f4a0bee33d19, 128'h3052411ee55db4b8f198bfe0ae1127d4);
        idle(20);

        // spot bytes in byte 15
        for (int i = 0; i < 4; i++) begin
            send({spot_in[i], 120'h0}, {spot_out[i], {15{8'h63}}});
            idle(18);
        end

        // request held high with the state changing every cycle
        en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            state_in = rand128();
            exp_in   = sub_state(state_in);
            tick();
        end
        en = 1'b0;
        idle(20);

        // reset two edges after accept, then a fresh block
        s = rand128();
        send(s, sub_state(s));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);
        s = rand128();
        send(s, sub_state(s));
        idle(20);

        // reset and request at the same edge
        rst = 1'b1; en = 1'b1;
        state_in = rand128();
        exp_in   = sub_state(state_in);
        tick();
        rst = 1'b0; en = 1'b0;
        idle(20);

        // completed output held while idle
        s = rand128();
        send(s, sub_state(s));
        idle(30);

        for (int i = 0; i < 3; i++) begin
            s = rand128();
            send(s, sub_state(s));
            idle(17);
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
